// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared fetch-unit types and constants: state encoding, default word width and PC step.
package pc_fetch_sequencer_pkg;

  localparam int unsigned DataWidth  = 32;
  localparam int unsigned InstrBytes = 4;

  typedef enum logic [2:0] {
    StIdle,
    StRequest,
    StHold,
    StJump,
    StFault
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// Fetch-unit bus bundle: ProgramCounter controls, instruction memory, decode and jump ports.
interface pc_fetch_sequencer_if #(
  parameter int unsigned DataWidth = 32
) ();

  logic [DataWidth-1:0] pc_value;
  logic [DataWidth-1:0] pc_data_in;
  logic                 pc_write_enable;
  logic                 pc_write_add;
  logic                 pc_count_enable;

  logic [DataWidth-1:0] mem_address;
  logic                 mem_valid;
  logic                 mem_ready;
  logic [DataWidth-1:0] mem_data;

  logic [DataWidth-1:0] instr_data;
  logic [DataWidth-1:0] instr_addr;
  logic                 instr_valid;
  logic                 instr_ready;

  logic                 jump_valid;
  logic                 jump_relative;
  logic [DataWidth-1:0] jump_target;
  logic                 jump_accept;

  logic                 fetch_fault;

  modport master (
    input  pc_value, mem_ready, mem_data, instr_ready, jump_valid, jump_relative, jump_target,
    output pc_data_in, pc_write_enable, pc_write_add, pc_count_enable, mem_address, mem_valid,
           instr_data, instr_addr, instr_valid, jump_accept, fetch_fault
  );

  modport slave (
    output pc_value, mem_ready, mem_data, instr_ready, jump_valid, jump_relative, jump_target,
    input  pc_data_in, pc_write_enable, pc_write_add, pc_count_enable, mem_address, mem_valid,
           instr_data, instr_addr, instr_valid, jump_accept, fetch_fault
  );

endinterface

// File: rtl/pc_fetch_sequencer_timeout_counter.sv
// Saturating stall counter; expired_o flags the count step that reaches TimeoutCycles.
module pc_fetch_sequencer_timeout_counter #(
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic count_i,
  output logic expired_o
);

  localparam int unsigned CntWidth = $clog2(TimeoutCycles + 1);
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(TimeoutCycles);

  logic [CntWidth-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (count_i && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Looks ahead one step so the FSM can leave on the cycle the limit is reached.
  assign expired_o = count_i && !clear_i && (cnt_q >= CntMax - 1'b1);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Instruction-fetch controller: steps the ProgramCounter, fetches one word per PC value,
// hands it to decode and arbitrates jump requests; sticky fault on bus timeout.
module pc_fetch_sequencer
  import pc_fetch_sequencer_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable_i,
  pc_fetch_sequencer_if.master  bus
);

  fetch_state_e         state_q, state_d;
  logic [DataWidth-1:0] instr_data_q, instr_addr_q;
  logic                 fault_q;

  logic capture;
  logic accept;
  logic cnt_clear;
  logic cnt_inc;
  logic cnt_expired;

  pc_fetch_sequencer_timeout_counter #(
    .TimeoutCycles (TimeoutCycles)
  ) u_timeout (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (cnt_clear),
    .count_i   (cnt_inc),
    .expired_o (cnt_expired)
  );

  always_comb begin
    state_d   = state_q;
    capture   = 1'b0;
    accept    = 1'b0;
    cnt_clear = 1'b0;
    cnt_inc   = 1'b0;

    bus.pc_data_in      = '0;
    bus.pc_write_enable = 1'b0;
    bus.pc_write_add    = 1'b0;
    bus.pc_count_enable = 1'b0;
    bus.mem_address     = '0;
    bus.mem_valid       = 1'b0;
    bus.instr_valid     = 1'b0;
    bus.jump_accept     = 1'b0;

    // Outputs are held quiet while reset is asserted.
    if (!reset) begin
      unique case (state_q)
        StIdle: begin
          if (bus.jump_valid) begin
            accept  = 1'b1;
            state_d = StJump;
          end else if (enable_i) begin
            state_d = StRequest;
          end
        end
        StRequest: begin
          bus.mem_valid   = 1'b1;
          bus.mem_address = bus.pc_value;
          if (bus.mem_ready) begin
            capture             = 1'b1;
            bus.pc_count_enable = 1'b1;
            cnt_clear           = 1'b1;
            state_d             = StHold;
          end else begin
            cnt_inc = 1'b1;
            if (cnt_expired) begin
              state_d = StFault;
            end
          end
        end
        StHold: begin
          bus.instr_valid = 1'b1;
          if (bus.jump_valid) begin
            accept  = 1'b1;
            state_d = StJump;
          end else if (bus.instr_ready) begin
            state_d = enable_i ? StRequest : StIdle;
          end
        end
        StJump: begin
          state_d = enable_i ? StRequest : StIdle;
        end
        StFault: begin
          state_d = StFault;
        end
        default: begin
          state_d = StIdle;
        end
      endcase

      if (accept) begin
        bus.jump_accept     = 1'b1;
        bus.pc_write_enable = 1'b1;
        bus.pc_write_add    = bus.jump_relative;
        bus.pc_data_in      = bus.jump_target;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      instr_data_q <= '0;
      instr_addr_q <= '0;
      fault_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        instr_data_q <= bus.mem_data;
        instr_addr_q <= bus.pc_value;
      end
      if (state_d == StFault) begin
        fault_q <= 1'b1;
      end
    end
  end

  assign bus.instr_data  = instr_data_q;
  assign bus.instr_addr  = instr_addr_q;
  assign bus.fetch_fault = fault_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed self-checking bench for pc_fetch_sequencer with a behavioural ProgramCounter.
module tb_pc_fetch_sequencer;
  import pc_fetch_sequencer_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;

  logic [31:0] pc_q = '0;
  logic        pc_force = 1'b0;
  logic [31:0] pc_force_val = '0;

  int n_cmp = 0;
  int n_err = 0;

  pc_fetch_sequencer_if #(.DataWidth(32)) bus ();

  pc_fetch_sequencer #(
    .TimeoutCycles (255)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable_i (enable),
    .bus      (bus.master)
  );

  always #5 clk = ~clk;

  assign bus.pc_value = pc_q;

  // Reference ProgramCounter driven by the DUT's controls.
  always @(posedge clk) begin
    if (pc_force) pc_q <= pc_force_val;
    else if (bus.pc_write_enable) pc_q <= bus.pc_write_add ? pc_q + bus.pc_data_in
                                                           : bus.pc_data_in;
    else if (bus.pc_count_enable) pc_q <= pc_q + InstrBytes;
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [31:0] pc0);
    reset = 1'b1;
    enable = 1'b0;
    bus.mem_ready = 1'b0;
    bus.mem_data = '0;
    bus.instr_ready = 1'b0;
    bus.jump_valid = 1'b0;
    bus.jump_relative = 1'b0;
    bus.jump_target = '0;
    pc_force = 1'b1;
    pc_force_val = pc0;
    tick();
    tick();
    reset = 1'b0;
    pc_force = 1'b0;
  endtask

  task automatic test_reset();
    logic [134:0] obs;
    @(negedge clk);
    do_reset(32'h0);
    reset = 1'b1;
    bus.mem_ready = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      obs = {bus.pc_data_in, bus.pc_write_enable, bus.pc_write_add, bus.pc_count_enable,
             bus.mem_address, bus.mem_valid, bus.instr_data, bus.instr_addr, bus.instr_valid,
             bus.jump_accept, bus.fetch_fault};
      n_cmp++;
      if (obs !== '0) begin
        n_err++;
        $display("FAIL reset_idle[%0d]: got %h want 0", i, obs);
      end
      tick();
    end
  endtask

  task automatic test_fetch_stream();
    logic [31:0] exp_addr;
    do_reset(32'h100);
    enable = 1'b1;
    bus.mem_ready = 1'b1;
    bus.mem_data = 32'h0000_0013;
    bus.instr_ready = 1'b1;
    #1;
    n_cmp++;
    if (bus.mem_valid !== 1'b0) begin
      n_err++;
      $display("FAIL idle_no_req: got %b want 0", bus.mem_valid);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      exp_addr = 32'h100 + 32'(i * 4);
      #1;
      n_cmp++;
      if ({bus.mem_valid, bus.mem_address, bus.pc_count_enable, bus.pc_write_enable} !==
          {1'b1, exp_addr, 1'b1, 1'b0}) begin
        n_err++;
        $display("FAIL stream_req[%0d]: got v=%b a=%h cnt=%b we=%b want v=1 a=%h cnt=1 we=0",
                 i, bus.mem_valid, bus.mem_address, bus.pc_count_enable,
                 bus.pc_write_enable, exp_addr);
      end
      tick();
      #1;
      n_cmp++;
      if ({bus.instr_valid, bus.instr_addr, bus.instr_data, bus.pc_count_enable, bus.mem_valid}
          !== {1'b1, exp_addr, 32'h0000_0013, 1'b0, 1'b0}) begin
        n_err++;
        $display("FAIL stream_hold[%0d]: got v=%b a=%h d=%h cnt=%b mv=%b want v=1 a=%h d=13",
                 i, bus.instr_valid, bus.instr_addr, bus.instr_data, bus.pc_count_enable,
                 bus.mem_valid, exp_addr);
      end
      tick();
    end
  endtask

  task automatic test_stall();
    do_reset(32'h200);
    enable = 1'b1;
    bus.mem_data = 32'hA5A5_5A5A;
    tick();
    bus.jump_valid = 1'b1;
    bus.jump_target = 32'h0000_0040;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if ({bus.mem_valid, bus.mem_address, bus.pc_count_enable, bus.instr_valid,
           bus.jump_accept, bus.pc_write_enable} !== {1'b1, 32'h200, 4'b0000}) begin
        n_err++;
        $display("FAIL stall_req[%0d]: got v=%b a=%h cnt=%b iv=%b ja=%b we=%b want v=1 a=200",
                 i, bus.mem_valid, bus.mem_address, bus.pc_count_enable, bus.instr_valid,
                 bus.jump_accept, bus.pc_write_enable);
      end
      tick();
    end
    bus.jump_valid = 1'b0;
    bus.mem_ready = 1'b1;
    #1;
    n_cmp++;
    if (bus.pc_count_enable !== 1'b1) begin
      n_err++;
      $display("FAIL stall_count: got %b want 1", bus.pc_count_enable);
    end
    tick();
    enable = 1'b0;
    bus.mem_ready = 1'b0;
    bus.mem_data = 32'h0;
    #1;
    n_cmp++;
    if ({bus.instr_valid, bus.instr_data, bus.instr_addr, pc_q} !==
        {1'b1, 32'hA5A5_5A5A, 32'h200, 32'h204}) begin
      n_err++;
      $display("FAIL stall_hold: got v=%b d=%h a=%h pc=%h want v=1 d=a5a55a5a a=200 pc=204",
               bus.instr_valid, bus.instr_data, bus.instr_addr, pc_q);
    end
    tick();
    #1;
    n_cmp++;
    if ({bus.instr_valid, bus.instr_data} !== {1'b1, 32'hA5A5_5A5A}) begin
      n_err++;
      $display("FAIL hold_stable: got v=%b d=%h want v=1 d=a5a55a5a",
               bus.instr_valid, bus.instr_data);
    end
    bus.instr_ready = 1'b1;
    tick();
    #1;
    n_cmp++;
    if ({bus.instr_valid, bus.mem_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL consume_idle: got iv=%b mv=%b want 0 0", bus.instr_valid, bus.mem_valid);
    end
  endtask

  task automatic test_jump_relative();
    do_reset(32'h10);
    enable = 1'b1;
    bus.mem_ready = 1'b1;
    bus.mem_data = 32'h1111_2222;
    tick();
    tick();
    bus.jump_valid = 1'b1;
    bus.jump_relative = 1'b1;
    bus.jump_target = 32'hFFFF_FFF8;
    bus.instr_ready = 1'b1;
    #1;
    n_cmp++;
    if ({bus.jump_accept, bus.pc_write_enable, bus.pc_write_add, bus.pc_data_in,
         bus.pc_count_enable, bus.instr_addr} !== {3'b111, 32'hFFFF_FFF8, 1'b0, 32'h10}) begin
      n_err++;
      $display("FAIL jrel_accept: got ja=%b we=%b add=%b d=%h cnt=%b ia=%h want 1 1 1 fffffff8 0 10",
               bus.jump_accept, bus.pc_write_enable, bus.pc_write_add, bus.pc_data_in,
               bus.pc_count_enable, bus.instr_addr);
    end
    tick();
    #1;
    n_cmp++;
    if ({pc_q, bus.instr_valid, bus.mem_valid, bus.jump_accept, bus.pc_write_enable} !==
        {32'h0C, 4'b0000}) begin
      n_err++;
      $display("FAIL jrel_settle: got pc=%h iv=%b mv=%b ja=%b we=%b want pc=c others 0",
               pc_q, bus.instr_valid, bus.mem_valid, bus.jump_accept, bus.pc_write_enable);
    end
    tick();
    bus.jump_valid = 1'b0;
    #1;
    n_cmp++;
    if ({bus.mem_valid, bus.mem_address} !== {1'b1, 32'h0C}) begin
      n_err++;
      $display("FAIL jrel_refetch: got v=%b a=%h want v=1 a=c", bus.mem_valid, bus.mem_address);
    end
  endtask

  task automatic test_jump_absolute();
    do_reset(32'h40);
    enable = 1'b1;
    bus.mem_ready = 1'b1;
    tick();
    tick();
    bus.jump_valid = 1'b1;
    bus.jump_relative = 1'b0;
    bus.jump_target = 32'hDEAD_BEEC;
    #1;
    n_cmp++;
    if ({bus.jump_accept, bus.pc_write_enable, bus.pc_write_add, bus.pc_data_in} !==
        {3'b110, 32'hDEAD_BEEC}) begin
      n_err++;
      $display("FAIL jabs_accept: got ja=%b we=%b add=%b d=%h want 1 1 0 deadbeec",
               bus.jump_accept, bus.pc_write_enable, bus.pc_write_add, bus.pc_data_in);
    end
    tick();
    bus.jump_valid = 1'b0;
    tick();
    #1;
    n_cmp++;
    if ({bus.mem_valid, bus.mem_address} !== {1'b1, 32'hDEAD_BEEC}) begin
      n_err++;
      $display("FAIL jabs_refetch: got v=%b a=%h want v=1 a=deadbeec",
               bus.mem_valid, bus.mem_address);
    end
  endtask

  task automatic test_idle_jump();
    do_reset(32'h80);
    bus.jump_valid = 1'b1;
    bus.jump_relative = 1'b1;
    bus.jump_target = 32'h20;
    #1;
    n_cmp++;
    if ({bus.jump_accept, bus.pc_write_add, bus.pc_data_in} !== {2'b11, 32'h20}) begin
      n_err++;
      $display("FAIL idle_jump: got ja=%b add=%b d=%h want 1 1 20",
               bus.jump_accept, bus.pc_write_add, bus.pc_data_in);
    end
    tick();
    bus.jump_valid = 1'b0;
    tick();
    #1;
    n_cmp++;
    if ({pc_q, bus.mem_valid, bus.jump_accept} !== {32'hA0, 2'b00}) begin
      n_err++;
      $display("FAIL idle_jump_back: got pc=%h mv=%b ja=%b want pc=a0 0 0",
               pc_q, bus.mem_valid, bus.jump_accept);
    end
  endtask

  task automatic test_reset_mid_request();
    do_reset(32'h500);
    enable = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    n_cmp++;
    if (bus.mem_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_req: got mv=%b want 0", bus.mem_valid);
    end
  endtask

  task automatic test_timeout();
    int bad;
    bad = 0;
    do_reset(32'h300);
    enable = 1'b1;
    tick();
    for (int i = 0; i < 255; i++) begin
      #1;
      if (!(bus.mem_valid === 1'b1 && bus.fetch_fault === 1'b0 && bus.mem_address === 32'h300))
        bad++;
      tick();
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL timeout_wait: got %0d bad cycles want 0", bad);
    end
    #1;
    n_cmp++;
    if ({bus.fetch_fault, bus.mem_valid, bus.instr_valid} !== 3'b100) begin
      n_err++;
      $display("FAIL timeout_fault: got ff=%b mv=%b iv=%b want 1 0 0",
               bus.fetch_fault, bus.mem_valid, bus.instr_valid);
    end
    bus.jump_valid = 1'b1;
    bus.mem_ready = 1'b1;
    #1;
    n_cmp++;
    if ({bus.jump_accept, bus.pc_write_enable} !== 2'b00) begin
      n_err++;
      $display("FAIL fault_jump: got ja=%b we=%b want 0 0", bus.jump_accept, bus.pc_write_enable);
    end
    tick();
    tick();
    #1;
    n_cmp++;
    if ({bus.fetch_fault, bus.mem_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL fault_sticky: got ff=%b mv=%b want 1 0", bus.fetch_fault, bus.mem_valid);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.jump_valid = 1'b0;
    #1;
    n_cmp++;
    if (bus.fetch_fault !== 1'b0) begin
      n_err++;
      $display("FAIL fault_clear: got %b want 0", bus.fetch_fault);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_fetch_stream();
    test_stall();
    test_jump_relative();
    test_jump_absolute();
    test_idle_jump();
    test_reset_mid_request();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
- Instruction-fetch controller that sequences the ProgramCounter.
- Drives the PC write/add/count controls and issues one instruction read per PC value on a valid/ready memory bus.
- Presents the fetched word to decode on a valid/ready handshake.
- Arbitrates jump requests against in-flight fetches; detects bus timeouts.

Parameters:
DATA_WIDTH, 32, width of PC, address and instruction words
INSTR_BYTES, 4, PC increment per fetch (documents the fixed +4 step of ProgramCounter countEnable)
TIMEOUT_CYCLES, 255, max consecutive memValid&&!memReady cycles before fault; counter width = clog2(TIMEOUT_CYCLES+1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
enable  in  1  run request; low = stop after current fetch
pcValue  in  DATA_WIDTH  current ProgramCounter output
pcDataIn  out  DATA_WIDTH  value/offset to ProgramCounter; 0 when pcWriteEnable=0
pcWriteEnable  out  1  PC write this edge
pcWriteAdd  out  1  1 = add pcDataIn to PC, 0 = set PC
pcCountEnable  out  1  PC += INSTR_BYTES this edge
memAddress  out  DATA_WIDTH  fetch address (= pcValue while memValid)
memValid  out  1  fetch request
memReady  in  1  memory completes request, memData valid same cycle
memData  in  DATA_WIDTH  fetched word
instrData  out  DATA_WIDTH  held instruction
instrAddr  out  DATA_WIDTH  address of held instruction
instrValid  out  1  instruction available
instrReady  in  1  decode consumes instruction
jumpValid  in  1  jump request
jumpRelative  in  1  1 = PC-relative, 0 = absolute
jumpTarget  in  DATA_WIDTH  absolute target or signed offset
jumpAccept  out  1  one-cycle pulse, jump taken this edge
fetchFault  out  1  sticky bus-timeout flag

Behaviour:
- Single clk, reset synchronous active-high. Reset: state IDLE; all outputs 0; instrData/instrAddr 0; timeout counter 0; fetchFault 0.
- States: IDLE, REQUEST, HOLD, JUMP, FAULT. PC/mem/jumpAccept controls are combinational from state and inputs (Mealy); instrData, instrAddr and fetchFault are registered.
- IDLE:
  - jumpValid -> accept jump (see Jump), go to JUMP.
  - else enable -> REQUEST.
  - else stay.
- REQUEST:
  - memValid=1, memAddress=pcValue.
  - memReady=1: capture instrData<=memData, instrAddr<=pcValue; pcCountEnable=1 the same cycle; counter cleared; go to HOLD.
  - memReady=0: counter++. The cycle the counter reaches TIMEOUT_CYCLES: go to FAULT, fetchFault<=1.
  - jumpValid is ignored (no accept) in REQUEST; bus transactions are never aborted except by reset.
- HOLD:
  - instrValid=1.
  - jumpValid has priority over instrReady: accept jump, discard held instruction (instrValid low next cycle), go to JUMP.
  - else instrReady: enable -> REQUEST, else IDLE.
  - else stay; instrData stable.
- Jump accept (IDLE or HOLD only):
  - Same cycle: jumpAccept=1, pcWriteEnable=1, pcWriteAdd=jumpRelative, pcDataIn=jumpTarget.
  - Relative offset is added to current pcValue. In HOLD that is instrAddr+INSTR_BYTES; the branch unit pre-compensates.
  - Add wraps modulo 2^DATA_WIDTH.
  - pcCountEnable is never asserted together with pcWriteEnable.
- JUMP: one settle cycle, no outputs asserted. Then enable -> REQUEST, else IDLE. A jumpValid in JUMP is not accepted.
- FAULT: memValid=0, instrValid=0, jumpAccept=0, fetchFault=1. Exit only by reset.
- Latency:
  - IDLE+enable with memReady tied 1: REQUEST at cycle 1, instrValid at cycle 2.
  - Best throughput: one instruction per 2 cycles.
- enable deasserted mid-REQUEST: fetch completes normally, HOLD, then IDLE after consume.
- Reset mid-REQUEST: memValid low from the next cycle; the memory bus must tolerate the abandoned request.

Decomposition:
- Shared cpu package holds: fetch state enum (IDLE/REQUEST/HOLD/JUMP/FAULT), DATA_WIDTH default, INSTR_BYTES constant.
- One sub-module is natural: fetch_timeout_counter (clear, count, saturate, expired flag).

Test Plan:
- Reset with memReady=1, enable=0 -> all outputs 0, state stays IDLE for 5 cycles, no mem request.
- PC at 0x100, enable=1, memReady=1, memData=0x00000013, instrReady=1 -> memAddress 0x100, then 0x104, 0x108; pcCountEnable one pulse per fetch; instrAddr matches each fetch address.
- memReady held low 3 cycles in REQUEST -> memValid and memAddress stable; instrValid 1 cycle after memReady rises; single PC increment.
- HOLD with instrAddr=0x10, jumpValid=1, jumpRelative=1, jumpTarget=0xFFFFFFF8, instrReady=1 same cycle -> jumpAccept, pcWriteAdd=1, PC becomes 0x0C; held instruction dropped; next fetch at 0x0C.
- HOLD with jumpRelative=0, jumpTarget=0xDEADBEEC -> pcWriteEnable=1, pcWriteAdd=0; next memAddress 0xDEADBEEC.
- memReady=0 for TIMEOUT_CYCLES (255) cycles -> fetchFault=1, memValid=0, later jumpValid ignored; reset clears fetchFault.
